question_gen: RTL and testbench
===============================

# question_gen

Random arithmetic question generator feeding `game_state` in the maths game. On request it draws an operation and two operands from a free-running 16-bit LFSR, computes the true result, then presents either the true result or a nearby wrong one. It flags which one it chose so the game logic can score the player's correct/wrong button press. All operands and results fit 8 bits, are non-negative, and division is always exact.

## Interface
- `SEED`, default 16'hACE1: LFSR reset value. 16'h0000 is illegal and is replaced by 16'hACE1.
- `clk`, in, 1: system clock (100 MHz).
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 1: request a new question. Sampled only in IDLE.
- `level`, in, 2: difficulty, latched when `req` is accepted. Maximum operand per level: 0→9, 1→12, 2→15, 3→15.
- `busy`, out, 1: high from the cycle after acceptance until DONE (exclusive).
- `valid`, out, 1: one-cycle pulse; question outputs are updated in the same cycle.
- `operand1`, out, 8: left operand.
- `operand2`, out, 8: right operand.
- `operation`, out, 2: 00 add, 01 sub, 10 mul, 11 div.
- `result`, out, 8: result shown to the player.
- `result_ok`, out, 1: 1 when `result` is the true answer.

## Operation
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle in every state except during reset, so request timing adds entropy.
- FSM states: IDLE, DRAW_OP, DRAW_A, DRAW_B, COMPUTE, PERTURB, DONE.
- **IDLE:** `req`=1 latches `level` and moves to DRAW_OP.
- **DRAW_OP:** op = lfsr[1:0].
- **DRAW_A / DRAW_B:**
  - Candidate n = lfsr[3:0]. Accept if 1 ≤ n ≤ MAX(level); otherwise stay and retry next cycle.
  - A 4-bit retry counter per draw forces acceptance after 16 rejections with n = (lfsr[2:0]) + 1.
- **COMPUTE:**
  - add: op1=a, op2=b, true=a+b.
  - sub: if a<b swap, so op1≥op2; true=op1−op2.
  - mul: op1=a, op2=b, true=a·b (≤225).
  - div: op1=a·b, op2=b, true=a.
- **PERTURB:**
  - lfsr[0]=1 → result=true, result_ok=1.
  - Otherwise delta = lfsr[2:1]+1 (1..4). Subtract delta if lfsr[3]=1 and true ≥ delta, else add delta. If the add exceeds 255, subtract instead.
  - result_ok=0. The wrong result is never equal to true and never wraps.
- **DONE:** outputs register, `valid`=1 for this one cycle, then return to IDLE. Outputs hold until the next DONE.
- `req` in any state other than IDLE is ignored; there is no queueing.

## Timing
- Reset (async assert, sync release): state=IDLE, lfsr=SEED, busy=0, valid=0, operand1=operand2=result=0, operation=00, result_ok=0.
- Latency with zero rejections: `req` sampled at edge k → `valid` high in the cycle following edge k+6.
- Each rejection adds 1 cycle. Maximum latency is 6+32=38 cycles.
- `busy` is high from edge k+1 up to the DONE edge. `busy` and `valid` are never high together.
- `rst_n` low mid-generation aborts immediately: no `valid`, outputs return to reset values.
- Back-to-back requests: earliest next acceptance is the cycle after DONE.

## Structure
- `maths_game_pkg` holds:
  - OP_ADD/OP_SUB/OP_MUL/OP_DIV encodings, shared with `game_state` and `game_display`;
  - the level→MAX table;
  - the FSM state enum;
  - LFSR taps and default seed.
- Sub-module `lfsr16` (clk, rst_n, seed, out[15:0]) is free-running and reusable by other game blocks.
- Arithmetic is a single 4×4→8 multiplier shared between mul and div.

## Test plan
- Reset check: hold `rst_n`=0 → all outputs 0, busy=0. Release, wait 100 cycles with no `req` → `valid` never asserts.
- Latency: 2000 requests at level 0 → every `valid` arrives 6..38 cycles after `req`, exactly one pulse per request, and `busy` is low when `valid` is high.
- Invariants over 5000 questions at each level:
  - operands ≤ MAX (mul/add/sub) or op2 ≤ MAX with op1 = quotient·op2 (div);
  - sub: op1 ≥ op2;
  - result_ok=1 ⇔ result equals the reference-model answer;
  - when wrong, |result−true| is 1..4 and result ≤ 255.
- Distribution: over 5000 questions, each operation appears 20–30%, and result_ok=1 appears 45–55%.
- Ignored request: pulse `req` again 2 cycles after acceptance → only one `valid`, with the `level` from the first request.
- Mid-operation reset: drop `rst_n` 3 cycles after `req` → no `valid`; after release, lfsr=SEED and the next question matches the golden model started from SEED.

Source files
------------

// File: rtl/maths_game_pkg.sv
// Shared encodings and helpers for the maths game: operation codes, level limits,
// question generator FSM states and the 16-bit LFSR definition.
package maths_game_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW_OP,
    ST_DRAW_A,
    ST_DRAW_B,
    ST_COMPUTE,
    ST_PERTURB,
    ST_DONE
  } state_t;

  function automatic logic [3:0] level_max(input logic [1:0] level);
    case (level)
      2'd0:    return 4'd9;
      2'd1:    return 4'd12;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; loads seed on reset and advances every cycle.
module lfsr16
  import maths_game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= seed;
    else        lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/question_gen.sv
// Arithmetic question generator: draws op and operands from the LFSR, computes the
// true answer and presents either it or a nearby wrong answer, flagged by result_ok.
module question_gen
  import maths_game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [1:0] level,
  output logic       busy,
  output logic       valid,
  output logic [7:0] operand1,
  output logic [7:0] operand2,
  output logic [1:0] operation,
  output logic [7:0] result,
  output logic       result_ok
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

  logic [15:0] lfsr;
  logic        lfsr_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SEED_EFF),
    .out   (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:4];

  state_t     state_q, state_d;
  logic [1:0] lvl_q, lvl_d;
  logic [1:0] op_q, op_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [3:0] retry_q, retry_d;
  logic       force_q, force_d;
  logic [7:0] op1_q, op1_d, op2_q, op2_d, true_q, true_d;
  logic [7:0] res_q, res_d;
  logic       ok_q, ok_d;
  logic       busy_q, busy_d, valid_q, valid_d;
  logic [7:0] operand1_q, operand1_d, operand2_q, operand2_d, result_q, result_d;
  logic [1:0] operation_q, operation_d;
  logic       result_ok_q, result_ok_d;

  logic [3:0] cand, draw_val;
  logic       cand_ok, draw_take;
  logic [7:0] prod;
  logic [2:0] delta;
  logic [8:0] sum9;
  logic       go_down;

  // A forced draw uses lfsr[2:0]+1, which is legal at every level.
  assign cand      = lfsr[3:0];
  assign cand_ok   = (cand != 4'd0) && (cand <= level_max(lvl_q));
  assign draw_take = cand_ok || force_q;
  assign draw_val  = cand_ok ? cand : ({1'b0, lfsr[2:0]} + 4'd1);

  // Single 4x4 multiplier shared by mul (a*b) and div (dividend = a*b).
  assign prod = 8'(a_q) * 8'(b_q);

  assign delta   = {1'b0, lfsr[2:1]} + 3'd1;
  assign sum9    = {1'b0, true_q} + 9'(delta);
  assign go_down = (lfsr[3] && (true_q >= 8'(delta))) || sum9[8];

  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    retry_d     = retry_q;
    force_d     = force_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    true_d      = true_q;
    res_d       = res_q;
    ok_d        = ok_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    operand1_d  = operand1_q;
    operand2_d  = operand2_q;
    operation_d = operation_q;
    result_d    = result_q;
    result_ok_d = result_ok_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          lvl_d   = level;
          busy_d  = 1'b1;
          state_d = ST_DRAW_OP;
        end
      end
      ST_DRAW_OP: begin
        op_d    = lfsr[1:0];
        retry_d = 4'd0;
        force_d = 1'b0;
        state_d = ST_DRAW_A;
      end
      ST_DRAW_A, ST_DRAW_B: begin
        if (draw_take) begin
          if (state_q == ST_DRAW_A) begin
            a_d     = draw_val;
            state_d = ST_DRAW_B;
          end else begin
            b_d     = draw_val;
            state_d = ST_COMPUTE;
          end
          retry_d = 4'd0;
          force_d = 1'b0;
        end else begin
          retry_d = retry_q + 4'd1;
          if (retry_q == 4'hF) force_d = 1'b1;
        end
      end
      ST_COMPUTE: begin
        op1_d  = 8'(a_q);
        op2_d  = 8'(b_q);
        true_d = 8'(a_q) + 8'(b_q);
        case (op_q)
          OP_SUB: begin
            if (a_q < b_q) begin
              op1_d  = 8'(b_q);
              op2_d  = 8'(a_q);
              true_d = 8'(b_q) - 8'(a_q);
            end else begin
              true_d = 8'(a_q) - 8'(b_q);
            end
          end
          OP_MUL:  true_d = prod;
          OP_DIV: begin
            op1_d  = prod;
            true_d = 8'(a_q);
          end
          default: ;
        endcase
        state_d = ST_PERTURB;
      end
      ST_PERTURB: begin
        if (lfsr[0]) begin
          res_d = true_q;
          ok_d  = 1'b1;
        end else begin
          res_d = go_down ? (true_q - 8'(delta)) : sum9[7:0];
          ok_d  = 1'b0;
        end
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        operand1_d  = op1_q;
        operand2_d  = op2_q;
        operation_d = op_q;
        result_d    = res_q;
        result_ok_d = ok_q;
        valid_d     = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lvl_q       <= 2'd0;
      op_q        <= 2'd0;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      retry_q     <= 4'd0;
      force_q     <= 1'b0;
      op1_q       <= 8'd0;
      op2_q       <= 8'd0;
      true_q      <= 8'd0;
      res_q       <= 8'd0;
      ok_q        <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      operand1_q  <= 8'd0;
      operand2_q  <= 8'd0;
      operation_q <= 2'd0;
      result_q    <= 8'd0;
      result_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      retry_q     <= retry_d;
      force_q     <= force_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      true_q      <= true_d;
      res_q       <= res_d;
      ok_q        <= ok_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      operand1_q  <= operand1_d;
      operand2_q  <= operand2_d;
      operation_q <= operation_d;
      result_q    <= result_d;
      result_ok_q <= result_ok_d;
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign operand1  = operand1_q;
  assign operand2  = operand2_q;
  assign operation = operation_q;
  assign result    = result_q;
  assign result_ok = result_ok_q;

endmodule

// File: tb/tb_question_gen.sv
// Bench for question_gen: a reference LFSR and question model feed an expected
// queue at request time; a monitor pops and checks each valid pulse.
module tb_question_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [1:0] level;
  logic       busy, valid, result_ok;
  logic [7:0] operand1, operand2, result;
  logic [1:0] operation;

  question_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .level     (level),
    .busy      (busy),
    .valid     (valid),
    .operand1  (operand1),
    .operand2  (operand2),
    .operation (operation),
    .result    (result),
    .result_ok (result_ok)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  o1;
    logic [7:0]  o2;
    logic [1:0]  op;
    logic [7:0]  res;
    logic        ok;
    logic [7:0]  tru;
    logic [31:0] lat;
    logic [31:0] stamp;
  } exp_t;

  exp_t exp_q[$];
  int   compared  = 0;
  int   failed    = 0;
  int   issued    = 0;
  int   valid_cnt = 0;
  int   cyc       = 0;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] nx(input logic [15:0] s);
    logic [15:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= nx(m_lfsr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // cur is the LFSR value in the cycle before the accepting edge.
  function automatic exp_t model(input logic [15:0] cur, input logic [1:0] lvl);
    exp_t e;
    logic [15:0] s;
    int mx, r, lat, a, b, t, o1, o2, dl, res, v;
    logic got;
    mx = (lvl == 2'd0) ? 9 : (lvl == 2'd1) ? 12 : 15;
    s = nx(cur);
    e.op = s[1:0];
    lat = 6;
    a = 0;
    for (int d = 0; d < 2; d++) begin
      s = nx(s);
      r = 0;
      got = 1'b0;
      v = 0;
      while (!got) begin
        if (int'(s[3:0]) >= 1 && int'(s[3:0]) <= mx) begin
          v = int'(s[3:0]);
          got = 1'b1;
        end else if (r == 16) begin
          v = int'(s[2:0]) + 1;
          got = 1'b1;
        end else begin
          r++;
          lat++;
          s = nx(s);
        end
      end
      if (d == 0) a = v;
      else b = v;
    end
    case (e.op)
      2'b00: begin o1 = a; o2 = b; t = a + b; end
      2'b01: begin o1 = (a >= b) ? a : b; o2 = (a >= b) ? b : a; t = o1 - o2; end
      2'b10: begin o1 = a; o2 = b; t = a * b; end
      default: begin o1 = a * b; o2 = b; t = a; end
    endcase
    s = nx(s);
    s = nx(s);
    if (s[0]) begin
      res = t;
      e.ok = 1'b1;
    end else begin
      dl = int'(s[2:1]) + 1;
      if ((s[3] && t >= dl) || (t + dl > 255)) res = t - dl;
      else res = t + dl;
      e.ok = 1'b0;
    end
    e.o1    = 8'(o1);
    e.o2    = 8'(o2);
    e.res   = 8'(res);
    e.tru   = 8'(t);
    e.lat   = 32'(lat);
    e.stamp = 32'(cyc);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid) begin
      valid_cnt++;
      chk("busy_with_valid", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        compared++;
        failed++;
        $display("FAIL unexpected_valid: got valid=1 expected no pulse");
      end else begin
        exp_t e;
        int diff;
        e = exp_q.pop_front();
        chk("operand1", {24'd0, operand1}, {24'd0, e.o1});
        chk("operand2", {24'd0, operand2}, {24'd0, e.o2});
        chk("operation", {30'd0, operation}, {30'd0, e.op});
        chk("result", {24'd0, result}, {24'd0, e.res});
        chk("result_ok", {31'd0, result_ok}, {31'd0, e.ok});
        chk("latency", 32'(cyc) - e.stamp - 32'd1, e.lat);
        if (!result_ok) begin
          diff = (int'(result) > int'(e.tru)) ? int'(result) - int'(e.tru)
                                              : int'(e.tru) - int'(result);
          chk("wrong_delta_in_range", {31'd0, (diff >= 1 && diff <= 4)}, 32'd1);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("valid_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic [1:0] lvl);
    wait_idle();
    @(negedge clk);
    req   = 1'b1;
    level = lvl;
    exp_q.push_back(model(m_lfsr, lvl));
    issued++;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_operand1"}, {24'd0, operand1}, 32'd0);
    chk({tag, "_operand2"}, {24'd0, operand2}, 32'd0);
    chk({tag, "_operation"}, {30'd0, operation}, 32'd0);
    chk({tag, "_result"}, {24'd0, result}, 32'd0);
    chk({tag, "_result_ok"}, {31'd0, result_ok}, 32'd0);
  endtask

  logic [1:0] lvl_tab[8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3};
  int         gap_tab[8] = '{0, 3, 1, 7, 2, 0, 5, 1};

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    level = 2'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    repeat (100) @(negedge clk);
    chk("idle_no_valid", 32'(valid_cnt), 32'd0);

    for (int i = 0; i < 48; i++) begin
      repeat (gap_tab[i % 8]) @(negedge clk);
      issue(lvl_tab[(i / 8 + i) % 8]);
    end

    // Second pulse lands in DRAW_A and must be ignored.
    issue(2'd0);
    @(negedge clk);
    req   = 1'b1;
    level = 2'd3;
    @(negedge clk);
    req = 1'b0;
    wait_idle();

    // Abort mid-generation; no expectation is queued for this request.
    @(negedge clk);
    req   = 1'b1;
    level = 2'd1;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(2'd2);
    issue(2'd3);
    issue(2'd0);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("valid_count", 32'(valid_cnt), 32'(issued));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
